// File: rtl/alu_selftest_pkg.sv
// Shared definitions for the ALU self-test driver: op encodings, FSM states,
// directed-vector table, LFSR stepping and the operand-scramble constant.
package alu_selftest_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_XOR = 3'b010,
        OP_SLT = 3'b011
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

    // Bit positions inside the 3-bit compare mask {out, cout, ov}
    localparam int unsigned MASK_OUT  = 2;
    localparam int unsigned MASK_COUT = 1;
    localparam int unsigned MASK_OV   = 0;

    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] B_SCRAMBLE = 32'hA5A5_5A5A;

    localparam int unsigned NUM_DIRECTED = 4;

    // Directed vectors, op implied by index: add, sub, xor, slt
    localparam logic [31:0] DIR_A [NUM_DIRECTED] = '{
        32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000
    };
    localparam logic [31:0] DIR_B [NUM_DIRECTED] = '{
        32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h7FFF_FFFF
    };

    // One right-shift step of the Galois LFSR
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/alu_selftest_driver_golden.sv
// Combinational golden model of the 32-bit ALU plus the per-op compare mask.
module alu_golden_model
    import alu_selftest_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] exp_out,
    output logic        exp_cout,
    output logic        exp_ov,
    output logic [2:0]  cmp_mask
);

    logic [32:0] sum;
    logic [31:0] diff;

    // Expected result and which fields are meaningful for the selected op
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = a - b;
        exp_out  = '0;
        exp_cout = 1'b0;
        exp_ov   = 1'b0;
        cmp_mask = '0;
        case (op)
            OP_ADD: begin
                exp_out  = sum[31:0];
                exp_cout = sum[32];
                exp_ov   = (a[31] == b[31]) && (sum[31] != a[31]);
                cmp_mask = 3'b111;
            end
            OP_SUB: begin
                exp_out  = diff;
                exp_ov   = (a[31] != b[31]) && (diff[31] != a[31]);
                cmp_mask = 3'b101;
            end
            OP_XOR: begin
                exp_out  = a ^ b;
                cmp_mask = 3'b100;
            end
            OP_SLT: begin
                // Signed compare directly, so overflow of a-b cannot corrupt it
                exp_out  = {31'b0, $signed(a) < $signed(b)};
                cmp_mask = 3'b100;
            end
            default: begin
                cmp_mask = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_selftest_driver.sv
// Sequential self-test initiator for the 32-bit ripple ALU: drives directed
// and LFSR operand sets, waits for settling, checks results, keeps counts.
module alu_selftest_driver
    import alu_selftest_pkg::*;
#(
    parameter int unsigned NUM_VECTORS   = 16,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [31:0] SEED          = 32'hACE1_2357
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_cout,
    input  logic        alu_overflow,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count,
    output logic        first_fail_valid,
    output logic [15:0] first_fail_index
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_e             state;
    logic [15:0]        index;
    logic [CNT_W-1:0]   settle_cnt;
    logic [31:0]        lfsr;

    logic [31:0]        vec_a;
    logic [31:0]        vec_b;
    logic [31:0]        exp_out;
    logic               exp_cout;
    logic               exp_ov;
    logic [2:0]         cmp_mask;
    logic               mismatch;

    // Golden model always looks at the operands actually presented to the ALU
    alu_golden_model u_golden (
        .a        (alu_a),
        .b        (alu_b),
        .op       (alu_op),
        .exp_out  (exp_out),
        .exp_cout (exp_cout),
        .exp_ov   (exp_ov),
        .cmp_mask (cmp_mask)
    );

    // Operand set for the current index: directed table first, then LFSR-derived
    always_comb begin
        vec_a = lfsr;
        vec_b = {lfsr[15:0], lfsr[31:16]} ^ B_SCRAMBLE;
        if (index < 16'(NUM_DIRECTED)) begin
            vec_a = DIR_A[index[1:0]];
            vec_b = DIR_B[index[1:0]];
        end
    end

    // Masked comparison of sampled ALU outputs against the golden model
    always_comb begin
        mismatch = (cmp_mask[MASK_OUT]  && (alu_out      != exp_out))  ||
                   (cmp_mask[MASK_COUT] && (alu_cout     != exp_cout)) ||
                   (cmp_mask[MASK_OV]   && (alu_overflow != exp_ov));
    end

    // Control FSM with settle/index counters, LFSR and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            index            <= '0;
            settle_cnt       <= '0;
            lfsr             <= SEED;
            alu_a            <= '0;
            alu_b            <= '0;
            alu_op           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_index <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state            <= S_APPLY;
                        index            <= '0;
                        settle_cnt       <= '0;
                        lfsr             <= SEED;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass_count       <= '0;
                        fail_count       <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_index <= '0;
                    end
                end
                S_APPLY: begin
                    // Operands register here so the full settle window follows
                    alu_a      <= vec_a;
                    alu_b      <= vec_b;
                    alu_op     <= {1'b0, index[1:0]};
                    settle_cnt <= '0;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (fail_count != 16'hFFFF) begin
                            fail_count <= fail_count + 16'd1;
                        end
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_index <= index;
                        end
                    end else if (pass_count != 16'hFFFF) begin
                        pass_count <= pass_count + 16'd1;
                    end
                    lfsr <= lfsr_next(lfsr);
                    if (index == 16'(NUM_VECTORS - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        index <= index + 16'd1;
                        state <= S_APPLY;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_selftest_driver.sv
// Bench for alu_selftest_driver: two instances (4 and 16 vectors) each beside a
// behavioural ALU; the 4-vector ALU has configurable delay and fault injection.
module tb_alu_selftest_driver;

    localparam logic [31:0] SEED = 32'hACE1_2357;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 4-vector instance
    logic        rst4, start4, busy4, done4, ffv4, cout4, ov4;
    logic [31:0] a4, b4, out4;
    logic [2:0]  op4;
    logic [15:0] pass4, fail4, ffi4;
    // 16-vector instance
    logic        rst16, start16, busy16, done16, ffv16, cout16, ov16;
    logic [31:0] a16, b16, out16;
    logic [2:0]  op16;
    logic [15:0] pass16, fail16, ffi16;

    int dly4 = 0;
    bit fault_xor = 1'b0;
    bit fault_subc = 1'b0;

    logic [31:0] exp_a [16];
    logic [31:0] exp_b [16];

    alu_selftest_driver #(.NUM_VECTORS(4), .SETTLE_CYCLES(8), .SEED(SEED)) dut4 (
        .clk(clk), .reset_n(rst4), .start(start4),
        .alu_a(a4), .alu_b(b4), .alu_op(op4),
        .alu_out(out4), .alu_cout(cout4), .alu_overflow(ov4),
        .busy(busy4), .done(done4), .pass_count(pass4), .fail_count(fail4),
        .first_fail_valid(ffv4), .first_fail_index(ffi4)
    );

    alu_selftest_driver #(.NUM_VECTORS(16), .SETTLE_CYCLES(8), .SEED(SEED)) dut16 (
        .clk(clk), .reset_n(rst16), .start(start16),
        .alu_a(a16), .alu_b(b16), .alu_op(op16),
        .alu_out(out16), .alu_cout(cout16), .alu_overflow(ov16),
        .busy(busy16), .done(done16), .pass_count(pass16), .fail_count(fail16),
        .first_fail_valid(ffv16), .first_fail_index(ffi16)
    );

    // Reference ALU from integer arithmetic; returns {out, cout, ov}
    function automatic logic [33:0] ideal_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        longint          sa, sb, s;
        longint unsigned ua, ub, u;
        logic [31:0]     r;
        logic            c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                u = ua + ub; r = u[31:0]; c = u[32];
                s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b; c = (ua >= ub);
                s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = a ^ b;
            3'd3: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {r, c, v};
    endfunction

    function automatic logic [33:0] faulty_alu(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] op, input bit fx, input bit fs);
        logic [33:0] r;
        r = ideal_alu(a, b, op);
        if (fx && op == 3'd2) r[2] = 1'b0;
        if (fs && op == 3'd1) r[1] = 1'b0;
        return r;
    endfunction

    // Delay line for the 4-vector instance's ALU
    logic [31:0] ha [16];
    logic [31:0] hb [16];
    logic [2:0]  ho [16];
    always @(posedge clk) begin
        ha[0] <= a4; hb[0] <= b4; ho[0] <= op4;
        for (int i = 1; i < 16; i++) begin
            ha[i] <= ha[i-1]; hb[i] <= hb[i-1]; ho[i] <= ho[i-1];
        end
    end
    always @* begin
        if (dly4 == 0) {out4, cout4, ov4} = faulty_alu(a4, b4, op4, fault_xor, fault_subc);
        else {out4, cout4, ov4} = faulty_alu(ha[dly4-1], hb[dly4-1], ho[dly4-1], fault_xor, fault_subc);
    end

    assign {out16, cout16, ov16} = ideal_alu(a16, b16, op16);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of a run over the first nv vectors with given faults
    task automatic model_run(input int nv, input bit fx, input bit fs,
                             output int p, output int f, output bit fv, output int fi);
        logic [33:0] good, got;
        logic [2:0]  op;
        bit          miss;
        p = 0; f = 0; fv = 1'b0; fi = 0;
        for (int i = 0; i < nv; i++) begin
            op   = 3'(i % 4);
            good = ideal_alu(exp_a[i], exp_b[i], op);
            got  = faulty_alu(exp_a[i], exp_b[i], op, fx, fs);
            if (op == 3'd0)      miss = (good != got);
            else if (op == 3'd1) miss = (good[33:2] != got[33:2]) || (good[0] != got[0]);
            else                 miss = (good[33:2] != got[33:2]);
            if (miss) begin
                f++;
                if (!fv) begin fv = 1'b1; fi = i; end
            end else p++;
        end
    endtask

    task automatic run4(output int cyc);
        @(negedge clk);
        start4 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            start4 = 1'b0;
            cyc++;
        end while (!done4 && cyc < 1000);
        check("run4_done_reached", 64'(done4), 64'd1);
    endtask

    task automatic run16(input bit chk_ops, input int pulse_at, input int reset_at, output int cyc);
        int k;
        @(negedge clk);
        start16 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            start16 = (cyc == pulse_at);
            cyc++;
            if (cyc == 1) begin
                check("start_clears_pass", 64'(pass16), 64'd0);
                check("start_busy", 64'(busy16), 64'd1);
            end
            if (chk_ops && (cyc % 10 == 6) && (cyc / 10 < 16)) begin
                k = cyc / 10;
                check($sformatf("op_a[%0d]", k), 64'(a16), 64'(exp_a[k]));
                check($sformatf("op_b[%0d]", k), 64'(b16), 64'(exp_b[k]));
                check($sformatf("op_op[%0d]", k), 64'(op16), 64'(k % 4));
            end
            if (cyc == reset_at) begin
                check("busy_before_reset", 64'(busy16), 64'd1);
                rst16 = 1'b0;
                #1;
                check("rst_mid_outputs", {a16, b16} | 64'(op16) | 64'(pass16) | 64'(fail16) |
                      64'(ffi16) | 64'({busy16, done16, ffv16}), 64'd0);
                @(negedge clk);
                rst16 = 1'b1;
                break;
            end
        end while (!done16 && cyc < 2000);
    endtask

    initial begin
        logic [31:0] lf;
        logic [31:0] da [4];
        logic [31:0] db [4];
        int cyc, p, f, fi;
        bit fv;

        da = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
        db = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h7FFF_FFFF};
        lf = SEED;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                exp_a[i] = da[i]; exp_b[i] = db[i];
            end else begin
                exp_a[i] = lf;
                exp_b[i] = {lf[15:0], lf[31:16]} ^ 32'hA5A5_5A5A;
            end
            lf = lf[0] ? ((lf >> 1) ^ 32'h8020_0003) : (lf >> 1);
        end

        rst4 = 1'b0; rst16 = 1'b0; start4 = 1'b0; start16 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_operands", {a4, b4} | 64'(op4), 64'd0);
        check("rst_counts", {32'd0, pass4, fail4}, 64'd0);
        check("rst_flags", 64'({busy4, done4, ffv4}) | 64'(ffi4), 64'd0);
        rst4 = 1'b1; rst16 = 1'b1;
        @(negedge clk);

        // Ideal ALU, 4 vectors
        run4(cyc);
        model_run(4, 1'b0, 1'b0, p, f, fv, fi);
        check("t1_latency", 64'(cyc), 64'd41);
        check("t1_pass", 64'(pass4), 64'(p));
        check("t1_fail", 64'(fail4), 64'(f));
        check("t1_ffv", 64'(ffv4), 64'(fv));
        check("t1_busy_done", 64'({busy4, done4}), 64'b01);
        check("t1_ops_hold", {a4, b4}, {32'h8000_0000, 32'h7FFF_FFFF});

        // xor out[0] stuck at 0
        fault_xor = 1'b1;
        run4(cyc);
        model_run(4, 1'b1, 1'b0, p, f, fv, fi);
        check("t3_fail", 64'(fail4), 64'(f));
        check("t3_pass", 64'(pass4), 64'(p));
        check("t3_ffv", 64'(ffv4), 64'(fv));
        check("t3_ffi", 64'(ffi4), 64'(fi));
        fault_xor = 1'b0;

        // sub cout stuck at 0 is outside the sub compare mask
        fault_subc = 1'b1;
        run4(cyc);
        check("t3_subc_fail", 64'(fail4), 64'd0);
        check("t3_subc_pass", 64'(pass4), 64'd4);
        fault_subc = 1'b0;

        // Slow ALU
        dly4 = 7;
        run4(cyc);
        check("t4_dly7_fail", 64'(fail4), 64'd0);
        dly4 = 9;
        run4(cyc);
        check("t4_dly9_fail_nonzero", 64'(fail4 > 0), 64'd1);
        dly4 = 0;

        // Full run with operand checks and a start pulse while busy
        run16(1'b1, 32, -1, cyc);
        check("t5_latency", 64'(cyc), 64'd161);
        check("t5_pass", 64'(pass16), 64'd16);
        check("t5_fail", 64'(fail16), 64'd0);

        // Restart from DONE: counts clear, operands reproduce
        run16(1'b1, -1, -1, cyc);
        check("t5_rerun_pass", 64'(pass16), 64'd16);

        // Reset during SETTLE of vector 5, then a clean run
        run16(1'b0, -1, 55, cyc);
        check("t6_cut_short", 64'(cyc), 64'd55);
        run16(1'b0, -1, -1, cyc);
        check("t6_latency", 64'(cyc), 64'd161);
        check("t6_pass", 64'(pass16), 64'd16);
        check("t6_fail_ffv", 64'({fail16, 15'd0, ffv16}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
